// File: rtl/scan_ramp_gen_pkg.sv
// Shared lock-datapath definitions: scan phase encoding plus the wide
// clamp/saturate helpers. The relock controller uses the same helpers.
package scan_ramp_gen_pkg;

    // Working width for ramp arithmetic. It leaves headroom for ramp +/- step
    // with data widths up to 32 bits, so intermediate sums never wrap.
    localparam int CW = 34;

    typedef logic signed [CW-1:0] wide_t;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_DWELL = 3'd1,
        PH_UP1   = 3'd2,
        PH_DOWN  = 3'd3,
        PH_UP2   = 3'd4
    } phase_t;

    // Bound v to the closed interval [lo, hi].
    function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Saturate v to the range of a w-bit signed number.
    function automatic wide_t saturate(input wide_t v, input int unsigned w);
        wide_t top;
        top = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        return clamp(v, -top - wide_t'(1), top);
    endfunction

endpackage

// File: rtl/scan_ramp_gen_if.sv
// Control/status bundle between the relock controller (master) and the
// scan ramp generator (slave).
interface scan_ramp_gen_if
    import scan_ramp_gen_pkg::*;
#(
    parameter int R    = 14,
    parameter int DIVW = 16
);
    logic                run;
    logic signed [R-1:0] low_lim;
    logic signed [R-1:0] hig_lim;
    logic [R-1:0]        step;
    logic [DIVW-1:0]     div;
    logic signed [R-1:0] ramp_out;
    logic                trigger;
    phase_t              phase;
    logic                busy;

    modport master (
        output run, low_lim, hig_lim, step, div,
        input  ramp_out, trigger, phase, busy
    );

    modport slave (
        input  run, low_lim, hig_lim, step, div,
        output ramp_out, trigger, phase, busy
    );
endinterface

// File: rtl/scan_ramp_gen_prescaler.sv
// Tick prescaler for the scan ramp: counts 0..div while enabled and
// flags a tick on the terminal count. Synchronous clear has priority.
module ramp_prescaler #(
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [DIVW-1:0] div,
    output logic            tick
);
    logic [DIVW-1:0] cnt_q;

    // ">=" rather than "==" so a div lowered mid-count still wraps at once
    // instead of running the full counter range.
    assign tick = en && (cnt_q >= div);

    // Prescaler count: wraps on tick, frozen while disabled.
    // NOTE: clocked state is always written with <= so every register samples
    // the pre-edge values; blocking writes here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + DIVW'(1);
        end
    end
endmodule

// File: rtl/scan_ramp_gen.sv
// Triangular scan generator: centre -> high -> low -> centre while run is
// high, one trigger pulse per completed period. Limits are latched only at
// the end of the centre dwell so the controller can retune between periods.
module scan_ramp_gen
    import scan_ramp_gen_pkg::*;
#(
    parameter int R     = 14,
    parameter int DIVW  = 16,
    parameter int DWELL = 16
) (
    input  logic             clk,
    input  logic             rst,
    scan_ramp_gen_if.slave   bus
);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    phase_t              state_q, state_d;
    logic signed [R-1:0] ramp_q, ramp_d;
    logic signed [R-1:0] lo_q, lo_d;
    logic signed [R-1:0] hi_q, hi_d;
    logic signed [R-1:0] ctr_q, ctr_d;
    logic                trig_q, trig_d;
    logic [7:0]          dcnt_q, dcnt_d;

    logic                pre_en, pre_clr, tick;
    logic signed [R-1:0] sel_lo, sel_hi;
    wide_t               ramp_w, lo_w, hi_w, ctr_w, step_w, centre_w;
    wide_t               target_w, next_w;

    ramp_prescaler #(.DIVW(DIVW)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .div  (bus.div),
        .tick (tick)
    );

    // Ordered limits and their floor midpoint, only consumed on the latch cycle.
    assign sel_lo   = (bus.low_lim <= bus.hig_lim) ? bus.low_lim : bus.hig_lim;
    assign sel_hi   = (bus.low_lim <= bus.hig_lim) ? bus.hig_lim : bus.low_lim;
    assign centre_w = (wide_t'(sel_lo) + wide_t'(sel_hi)) >>> 1;

    assign ramp_w = wide_t'(ramp_q);
    assign lo_w   = wide_t'(lo_q);
    assign hi_w   = wide_t'(hi_q);
    assign ctr_w  = wide_t'(ctr_q);
    // A zero step would stall the scan forever, so it behaves as one LSB.
    assign step_w = (bus.step == '0) ? wide_t'(1) : wide_t'({1'b0, bus.step});

    // Next-state and datapath update for the scan sequencer.
    // NOTE: every signal assigned below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        ramp_d   = ramp_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        ctr_d    = ctr_q;
        trig_d   = 1'b0;
        dcnt_d   = '0;
        pre_en   = 1'b0;
        pre_clr  = 1'b0;
        target_w = ctr_w;
        next_w   = ramp_w;

        if (!bus.run) begin
            // Dropping run always wins: park in IDLE with the output held.
            state_d = PH_IDLE;
        end else begin
            case (state_q)
                PH_IDLE: begin
                    state_d = PH_DWELL;
                end
                PH_DWELL: begin
                    if (dcnt_q == DWELL_LAST) begin
                        lo_d    = sel_lo;
                        hi_d    = sel_hi;
                        ctr_d   = R'(saturate(centre_w, R));
                        ramp_d  = R'(saturate(centre_w, R));
                        pre_clr = 1'b1;
                        state_d = PH_UP1;
                    end else begin
                        dcnt_d = dcnt_q + 8'd1;
                    end
                end
                PH_UP1, PH_DOWN, PH_UP2: begin
                    pre_en = 1'b1;
                    case (state_q)
                        PH_UP1:  target_w = hi_w;
                        PH_DOWN: target_w = lo_w;
                        default: target_w = ctr_w;
                    endcase
                    if (state_q == PH_DOWN) begin
                        next_w = clamp(ramp_w - step_w, target_w, hi_w);
                    end else begin
                        next_w = clamp(ramp_w + step_w, lo_w, target_w);
                    end
                    if (tick) begin
                        ramp_d = R'(saturate(next_w, R));
                        if (next_w == target_w) begin
                            case (state_q)
                                PH_UP1:  state_d = PH_DOWN;
                                PH_DOWN: state_d = PH_UP2;
                                default: begin
                                    state_d = PH_DWELL;
                                    trig_d  = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_d = PH_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, all returned to zero by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_IDLE;
            ramp_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ctr_q   <= '0;
            trig_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ctr_q   <= ctr_d;
            trig_q  <= trig_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign bus.ramp_out = ramp_q;
    assign bus.trigger  = trig_q;
    assign bus.phase    = state_q;
    assign bus.busy     = (state_q != PH_IDLE);

endmodule

// File: tb/tb_scan_ramp_gen.sv
// Scoreboard bench for scan_ramp_gen: a period-level reference model plans
// the per-cycle outputs; a monitor compares them against the DUT.
module tb_scan_ramp_gen;
    import scan_ramp_gen_pkg::*;

    localparam int R     = 14;
    localparam int DIVW  = 16;
    localparam int DWELL = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    scan_ramp_gen_if #(.R(R), .DIVW(DIVW)) bus ();

    scan_ramp_gen #(.R(R), .DIVW(DIVW), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int ramp;
        bit trig;
        int ph;
    } exp_t;

    exp_t exp_q[$];
    int   trig_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // stimulus knobs
    bit s_rst;
    bit s_run;
    int s_lo, s_hi, s_step, s_div;

    // reference model state: 0 idle, 1 dwelling, 2 sweeping a planned period
    int   m_mode = 0;
    int   m_left = 0;
    int   m_cur  = 0;
    int   m_last_ph = 0;
    exp_t m_plan[$];

    function automatic exp_t mk(input int r, input bit t, input int p);
        exp_t e;
        e.ramp = r;
        e.trig = t;
        e.ph   = p;
        return e;
    endfunction

    // One sweep leg: one entry per clock, value moves every div+1 clocks.
    function automatic void add_seg(inout int v, input int target, input int ph,
                                    input int nph, input int st, input bit last);
        int nv;
        do begin
            if (ph == int'(PH_DOWN)) nv = (v - st < target) ? target : v - st;
            else                     nv = (v + st > target) ? target : v + st;
            for (int k = 0; k < s_div; k++) m_plan.push_back(mk(v, 1'b0, ph));
            m_plan.push_back(mk(nv, last && (nv == target), (nv == target) ? nph : ph));
            v = nv;
        end while (v != target);
    endfunction

    function automatic void build_period();
        int lo, hi, s, c, st, v;
        lo = (s_lo < s_hi) ? s_lo : s_hi;
        hi = (s_lo < s_hi) ? s_hi : s_lo;
        s  = lo + hi;
        c  = (s >= 0) ? s / 2 : -((1 - s) / 2);
        st = (s_step == 0) ? 1 : s_step;
        m_plan.delete();
        m_cur = c;
        v = c;
        add_seg(v, hi, int'(PH_UP1),  int'(PH_DOWN),  st, 1'b0);
        add_seg(v, lo, int'(PH_DOWN), int'(PH_UP2),   st, 1'b0);
        add_seg(v, c,  int'(PH_UP2),  int'(PH_DWELL), st, 1'b1);
    endfunction

    function automatic void model_step();
        exp_t e;
        if (s_rst) begin
            m_plan.delete();
            m_mode = 0;
            m_cur  = 0;
            e = mk(0, 1'b0, int'(PH_IDLE));
        end else if (!s_run) begin
            m_plan.delete();
            m_mode = 0;
            e = mk(m_cur, 1'b0, int'(PH_IDLE));
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_left = DWELL;
            e = mk(m_cur, 1'b0, int'(PH_DWELL));
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                build_period();
                m_mode = 2;
                e = mk(m_cur, 1'b0, int'(PH_UP1));
            end else begin
                e = mk(m_cur, 1'b0, int'(PH_DWELL));
            end
        end else begin
            e = m_plan.pop_front();
            m_cur = e.ramp;
            if (e.trig) begin
                m_mode = 1;
                m_left = DWELL;
            end
        end
        m_last_ph = e.ph;
        exp_q.push_back(e);
    endfunction

    task automatic tick_cycle();
        @(negedge clk);
        rst         = s_rst;
        bus.run     = s_run;
        bus.low_lim = R'(s_lo);
        bus.hig_lim = R'(s_hi);
        bus.step    = R'(s_step);
        bus.div     = DIVW'(s_div);
        model_step();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic wait_phase(input int ph, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            tick_cycle();
            if (m_last_ph == ph) break;
        end
        n_checks++;
        if (i == budget) begin
            n_fail++;
            $display("FAIL %s: phase %0d not reached within %0d cycles", name, ph, budget);
        end
    endtask

    // Stop one cycle short of a UP2 completion so the caller can act on it.
    task automatic wait_last_tick(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_mode == 2 && m_plan.size() == 1) break;
            tick_cycle();
        end
        n_checks++;
        if (i == budget) begin
            n_fail++;
            $display("FAIL %s: period end not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic check_period(input int want, input string name);
        int got;
        n_checks++;
        if (trig_q.size() < 2) begin
            n_fail++;
            $display("FAIL %s: only %0d triggers seen, required >= 2", name, trig_q.size());
        end else begin
            got = trig_q[trig_q.size()-1] - trig_q[trig_q.size()-2];
            if (got != want) begin
                n_fail++;
                $display("FAIL %s: period %0d, required %0d", name, got, want);
            end
        end
    endtask

    task automatic go_idle(input int n);
        s_run = 1'b0;
        run_cycles(n);
    endtask

    // Monitor: sample just after each rising edge and compare with the plan.
    initial begin
        exp_t        e;
        logic [R-1:0] exp_r;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.trigger === 1'b1) trig_q.push_back(cyc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_r = R'(e.ramp);
                n_checks++;
                if (bus.ramp_out !== exp_r || bus.trigger !== e.trig ||
                    bus.phase !== 3'(e.ph) || bus.busy !== (e.ph != 0)) begin
                    n_fail++;
                    $display("FAIL out@%0d: ramp=%0d trig=%b phase=%0d busy=%b, required ramp=%0d trig=%b phase=%0d busy=%b",
                             cyc, $signed(bus.ramp_out), bus.trigger, bus.phase, bus.busy,
                             e.ramp, e.trig, e.ph, (e.ph != 0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        s_rst = 1'b1; s_run = 1'b0;
        s_lo = -8; s_hi = 8; s_step = 4; s_div = 0;
        rst = 1'b1; bus.run = 1'b0; bus.low_lim = '0; bus.hig_lim = '0;
        bus.step = '0; bus.div = '0;

        run_cycles(3);
        s_rst = 1'b0;
        run_cycles(2);

        // basic +-8 sweep, div 0
        s_run = 1'b1; trig_q.delete();
        run_cycles(1 + DWELL + 24 * 2 + 2);
        check_period(24, "period_div0");
        go_idle(3);

        // same sweep with each value held 3 clocks
        s_div = 2; s_run = 1'b1; trig_q.delete();
        run_cycles(1 + DWELL + 40 * 2 + 2);
        check_period(40, "period_div2");
        go_idle(3);

        // top of range: clamping without wrap
        s_lo = 8000; s_hi = 8191; s_step = 1000; s_div = 0; s_run = 1'b1;
        run_cycles(60);
        go_idle(2);

        // bottom of range
        s_lo = -8192; s_hi = -8000; s_run = 1'b1;
        run_cycles(60);
        go_idle(2);

        // widen limits mid-DOWN: takes effect next period
        s_lo = -8; s_hi = 8; s_step = 4; s_run = 1'b1;
        wait_phase(int'(PH_DOWN), 200, "wait_down_widen");
        s_lo = -16; s_hi = 16;
        run_cycles(100);
        go_idle(2);

        // swapped limits
        s_lo = 5; s_hi = -5; s_step = 3; s_run = 1'b1;
        run_cycles(80);
        go_idle(2);

        // zero span: one tick per phase
        s_lo = 3; s_hi = 3; s_run = 1'b1; trig_q.delete();
        run_cycles(70);
        check_period(DWELL + 3, "period_zero_span");
        go_idle(2);

        // step 0 behaves as step 1
        s_lo = -2; s_hi = 2; s_step = 0; s_div = 1; s_run = 1'b1;
        run_cycles(80);
        go_idle(2);

        // run drop mid-DOWN, then restart
        s_lo = -8; s_hi = 8; s_step = 4; s_div = 0; s_run = 1'b1;
        wait_phase(int'(PH_DOWN), 200, "wait_down_drop");
        run_cycles(1);
        s_run = 1'b0; run_cycles(5);
        s_run = 1'b1;
        // run drop on the very cycle UP2 completes: no trigger
        wait_last_tick(200, "wait_last_tick");
        s_run = 1'b0; run_cycles(4);
        s_run = 1'b1;

        // reset mid-UP1
        wait_phase(int'(PH_UP1), 200, "wait_up1_rst");
        run_cycles(1);
        s_rst = 1'b1; run_cycles(1);
        s_rst = 1'b0; run_cycles(30);
        go_idle(2);

        // randomized rounds
        for (int r = 0; r < 20; r++) begin
            s_div  = $urandom_range(0, 3);
            s_step = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(300, 16383);
            s_lo   = $urandom_range(0, 16383) - 8192;
            s_hi   = $urandom_range(0, 16383) - 8192;
            s_run  = 1'b1;
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    s_lo = $urandom_range(0, 16383) - 8192;
                    s_hi = $urandom_range(0, 16383) - 8192;
                end
                s_run = ($urandom_range(0, 7) != 0);
                run_cycles($urandom_range(10, 40));
            end
            go_idle(2);
        end

        go_idle(3);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_ramp_gen.md
# scan_ramp_gen

Triangular scan generator driven by the relock controller: while `run` is high it sweeps `ramp_out` centre → high limit → low limit → centre and pulses `trigger` once per completed period. Limits are re-latched only during a centre dwell at each period boundary, so the controller can widen the scan between periods without glitching the output. It sits between the relock controller and the actuator output mux in the lock datapath.

## Interface
- `R`, 14: data width of limits and ramp output (signed)
- `DIVW`, 16: width of the tick prescaler
- `DWELL`, 16: clock cycles spent at centre before limits are latched (range 1..255)
- `clk`  in  1  system clock
- `rst`  in  1  reset: synchronous, active-high; clock is `clk`
- `run`  in  1  scan enable (level)
- `low_lim`  in  R  signed lower scan limit
- `hig_lim`  in  R  signed upper scan limit
- `step`  in  R  unsigned increment per tick; 0 is treated as 1
- `div`  in  DIVW  prescaler; one tick every `div+1` clocks
- `ramp_out`  out  R  signed ramp value (registered)
- `trigger`  out  1  one-cycle pulse at the end of each completed period
- `phase`  out  3  current state encoding
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DWELL, UP1 (centre→hi), DOWN (hi→lo), UP2 (lo→centre).
- IDLE: `ramp_out` holds. Leaves for DWELL on the first cycle `run`=1.
- DWELL: counts `DWELL` clocks with `ramp_out` unchanged. On the last dwell cycle it latches lo_l=min(low_lim,hig_lim) and hi_l=max(low_lim,hig_lim), sets centre=(lo_l+hi_l)>>>1 (R+1-bit sum, floor), loads `ramp_out`=centre, clears the prescaler, and enters UP1.
- Tick: the prescaler counts 0..`div`; a tick occurs when the count equals `div`. The prescaler runs only in UP1, DOWN and UP2.
- On each tick in a moving phase: next = `ramp_out` ± step, computed in R+1 bits and clamped to the phase target (hi_l, lo_l or centre). Then `ramp_out`=next. If next equals the target, advance UP1→DOWN→UP2.
  - If the value already equals the target at a tick, the phase still consumes that tick.
- UP2 reaching centre: `trigger`=1 for exactly that cycle (same edge as the final `ramp_out` update), and the state enters DWELL.
- `run`=0 in any state: next state is IDLE, `ramp_out` holds, and no trigger is issued. A later `run`=1 restarts from DWELL.
- Latched limits never change outside the DWELL latch cycle. Input changes mid-period take effect in the next period.

## Timing
- Reset values: `ramp_out`=0, `trigger`=0, `phase`=IDLE, `busy`=0, prescaler=0, dwell counter=0, lo_l=hi_l=centre=0.
- `run` rise to first movement: DWELL+1 clocks. `ramp_out` equals centre after DWELL clocks.
- Period (trigger to trigger) with `div`=0 = DWELL + ticks(UP1)+ticks(DOWN)+ticks(UP2). Each phase takes ceil(distance/step), minimum 1.
- Controller contract: the controller's limit update after `trigger` lands in fewer than DWELL clocks, so DWELL ≥ 12 is required.
- `run` fall on the same cycle as a UP2 completion: IDLE wins and `trigger` stays 0.
- `rst` mid-operation: all registers return to their reset values on the next edge.

## Structure
- Shared lock package: state encoding constants (IDLE=0, DWELL=1, UP1=2, DOWN=3, UP2=4) and the R+1-bit clamp function, also used by the relock controller.
- One natural sub-module, `ramp_prescaler`: a DIVW counter with tick output and synchronous clear.
- The clamp reuses the existing saturation block for the R+1→R conversion of centre and next.

## Test plan
- low=-8, hig=8, step=4, div=0, DWELL=16, `run`=1 → `ramp_out` 0 for 16 cycles, then 4,8,4,0,-4,-8,-4,0. `trigger` fires on the final 0; trigger-to-trigger period = 24 clocks.
- Same setup with div=2 → each value is held 3 clocks; period = 16+8·3 = 40.
- low=8000, hig=8191, step=1000 → centre=8095, sequence 8191, 8000, 8095 with clamping and no wrap. low=-8192, hig=-8000 → no negative overflow.
- Change limits to ±16 mid-DOWN → the current period finishes at ±8; the next period spans ±16 after the dwell latch.
- low=5, hig=-5 (swapped) → sweeps -5..5 around centre 0. low=hig=3 → each phase takes 1 tick at 3; trigger every 16+3 clocks.
- Deassert `run` mid-DOWN → IDLE next cycle, `ramp_out` holds, `trigger` stays 0. Reassert `rst` mid-UP1 → all outputs at reset values next cycle.
